reg_file_sb: RTL
================

# reg_file_sb

Parametrised RISC-V integer register file with two combinational read ports, two write ports and an integrated per-register scoreboard. Port A carries ALU writeback; port B carries the load/long-latency writeback. Write-to-read bypass is built in. The scoreboard tracks registers with results in flight and raises `stall` to the issue stage on RAW and WAW hazards. It sits between decode/issue and the execute/writeback stages of the pipelined core.

## Interface
Parameters:
- `XLEN`, 32, data width of each register
- `NREG`, 32, number of architectural registers; power of two, ≥ 2
- `AW`, $clog2(NREG), address width; derived, not overridden

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rs1_addr`, `rs2_addr`  in  AW  read addresses
- `rs1_data`, `rs2_data`  out  XLEN  read data (combinational, bypassed)
- `issue_valid`  in  1  instruction presented for issue this cycle
- `issue_use_rs1`, `issue_use_rs2`  in  1  instruction actually reads rs1 / rs2
- `issue_rd`  in  AW  destination of presented instruction (0 = no destination)
- `stall`  out  1  presented instruction must not issue this cycle
- `wa_en`  in  1  port A write enable
- `wa_addr`  in  AW  port A write address
- `wa_data`  in  XLEN  port A write data
- `wb_en`  in  1  port B write enable
- `wb_addr`  in  AW  port B write address
- `wb_data`  in  XLEN  port B write data
- `pending`  out  NREG  scoreboard bits; bit i set = result for register i in flight
- `collision`  out  1  sticky flag: both ports wrote the same nonzero address in one cycle

## Operation
- Register 0:
  - Always reads 0.
  - Writes to it are discarded.
  - Its pending bit is constant 0.
  - It never causes a stall or a collision.
- Effective write on a port: enable high and address ≠ 0.
- Read path, per port, in priority order:
  - address 0 → 0;
  - else matching port B effective write → `wb_data`;
  - else matching port A effective write → `wa_data`;
  - else stored value.
- Write commit: on rising edge, each effective write updates its register. If both ports target the same address, port B's data is stored and `collision` sets.
- Clear view of a pending bit this cycle: `pending[i]` AND NOT (effective write to i on either port).
- `stall` (combinational) = `issue_valid` AND any of:
  - `issue_use_rs1` and rs1 pending in the clear view;
  - `issue_use_rs2` and rs2 pending in the clear view;
  - `issue_rd` ≠ 0 and `issue_rd` pending in the clear view (WAW).
- Issue accepted = `issue_valid` AND NOT `stall`.
- Pending update at rising edge:
  - set bit `issue_rd` if issue accepted and `issue_rd` ≠ 0;
  - clear any bit written by an effective write;
  - set wins over clear on the same bit in the same cycle (the new issue is younger).
- Writes to a register not pending are legal; data is stored and the bit stays 0.
- `collision` clears only on reset.

## Timing
- Reset (`rst_n` low, asynchronous, takes effect without a clock edge): all registers, `pending` and `collision` go to 0.
  - `rs1_data`/`rs2_data` then read 0, except bypassed write data.
  - `stall` is 0 because all pending bits are 0.
- Reset deassertion: state holds until the first rising edge with `rst_n` high.
- Reset asserted mid-operation: in-flight pending bits are lost, and writes presented in that cycle are not committed.
- Read latency 0: a write presented in cycle N is visible on read ports in cycle N (bypass) and from storage in N+1 onward.
- `stall` is purely combinational from the current inputs and `pending`. It has no registered delay.
- A writeback in cycle N unblocks a dependent issue in cycle N.
- Scoreboard: a register issued in cycle N shows `pending` high from N+1 until the edge closing its writeback cycle.
- Port A and port B are both fully independent each cycle, with no other back-pressure.

## Test plan
- Reset and x0:
  - stimulus: write 0xDEADBEEF to x0 via both ports, then read x0 on both read ports;
  - required: reads 0 on both ports, `pending`=0, `collision`=0;
  - then assert `rst_n` low mid-cycle: all state is 0 immediately.
- Bypass:
  - stimulus: port A writes x5=0x11111111 and port B writes x6=0x22222222 in the same cycle, with rs1=x5, rs2=x6;
  - required: same-cycle reads 0x11111111 and 0x22222222; next cycle the same values come from storage.
- RAW stall and release:
  - stimulus: issue rd=x7 (accepted); next cycle, issue with use_rs1 and rs1=x7;
  - required: `stall`=1 each cycle until port B writes x7=0x5A5A5A5A; in that cycle `stall`=0, `rs1_data`=0x5A5A5A5A, and `pending[7]` is 0 afterwards.
- WAW and set-over-clear:
  - stimulus: with x9 pending, issue rd=x9 while port A writes x9;
  - required: `stall`=0, issue accepted, `pending[9]` remains 1 after the edge;
  - stimulus: with x9 pending and no write, issue rd=x9;
  - required: `stall`=1.
- Collision:
  - stimulus: port A writes x3=0xAAAA0000 and port B writes x3=0x0000BBBB in one cycle;
  - required: x3 reads 0x0000BBBB (same cycle and after), `collision`=1 and stays 1 until reset.
- Parametrisation:
  - stimulus: XLEN=64, NREG=16; write x15=0xFFFF_FFFF_0000_0001;
  - required: reads back exactly that value, with correct stall on x15 and a 16-bit `pending` vector.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: RISC-V integer register file with an integrated result scoreboard.
//
// Provides two combinational read ports with write-to-read bypass and two write
// ports. Port A is the ALU writeback and port B is the load/long-latency writeback.
// A per-register pending bit tracks results still in flight. The stall output
// blocks issue on RAW and WAW hazards.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   rs1_addr/rs2_addr             read addresses
//   rs1_data/rs2_data             bypassed read data (combinational)
//   issue_valid, issue_use_rs1/2  instruction presented for issue and its operand use
//   issue_rd                      destination of the presented instruction (0 = none)
//   stall                         presented instruction must not issue (combinational)
//   wa_en/wa_addr/wa_data         port A write
//   wb_en/wb_addr/wb_data         port B write (wins on same-address conflict)
//   pending                       scoreboard bits, bit i = result for x<i> in flight
//   collision                     sticky: both ports wrote the same nonzero register
module reg_file_sb #(
   parameter  int unsigned XLEN = 32,
   parameter  int unsigned NREG = 32,
   localparam int unsigned AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic            issue_valid,
   input  logic            issue_use_rs1,
   input  logic            issue_use_rs2,
   input  logic [AW-1:0]   issue_rd,
   output logic            stall,
   input  logic            wa_en,
   input  logic [AW-1:0]   wa_addr,
   input  logic [XLEN-1:0] wa_data,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic [NREG-1:0] pending,
   output logic            collision
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] pending_q;
   logic [NREG-1:0] pending_d;
   logic            collision_q;
   logic            collision_d;

   logic            wa_eff;
   logic            wb_eff;
   logic [NREG-1:0] wa_hit;
   logic [NREG-1:0] wb_hit;
   logic [NREG-1:0] clear_view;
   logic            rd_nz;
   logic            issue_acc;

   // Effective writes: enabled and not targeting x0.
   assign wa_eff = wa_en && (wa_addr != '0);
   assign wb_eff = wb_en && (wb_addr != '0);
   assign rd_nz  = (issue_rd != '0);

   // One-hot decode of the registers being written this cycle.
   always_comb begin
      wa_hit = '0;
      wb_hit = '0;
      if (wa_eff) wa_hit[wa_addr] = 1'b1;
      if (wb_eff) wb_hit[wb_addr] = 1'b1;
   end

   // A writeback in flight this cycle already resolves its hazard.
   assign clear_view = pending_q & ~(wa_hit | wb_hit);

   // Hazard detection: RAW on either used source, WAW on a nonzero destination.
   always_comb begin
      stall = 1'b0;
      if (issue_valid) begin
         if (issue_use_rs1 && clear_view[rs1_addr]) stall = 1'b1;
         if (issue_use_rs2 && clear_view[rs2_addr]) stall = 1'b1;
         if (rd_nz && clear_view[issue_rd])         stall = 1'b1;
      end
   end

   assign issue_acc = issue_valid && !stall;

   // Read port 1: later assignments take priority (x0, then B, then A, then storage).
   always_comb begin
      rs1_data = regs_q[rs1_addr];
      if (wa_eff && (wa_addr == rs1_addr)) rs1_data = wa_data;
      if (wb_eff && (wb_addr == rs1_addr)) rs1_data = wb_data;
      if (rs1_addr == '0)                  rs1_data = '0;
   end

   // Read port 2: same priority as port 1.
   always_comb begin
      rs2_data = regs_q[rs2_addr];
      if (wa_eff && (wa_addr == rs2_addr)) rs2_data = wa_data;
      if (wb_eff && (wb_addr == rs2_addr)) rs2_data = wb_data;
      if (rs2_addr == '0)                  rs2_data = '0;
   end

   // Storage next state: port B applied last so it wins a same-address conflict.
   always_comb begin
      regs_d = regs_q;
      if (wa_eff) regs_d[wa_addr] = wa_data;
      if (wb_eff) regs_d[wb_addr] = wb_data;
      regs_d[0] = '0;
   end

   // Scoreboard next state: clear on writeback, then set for a newly accepted
   // issue so that the younger instruction's claim survives.
   always_comb begin
      pending_d = pending_q & ~(wa_hit | wb_hit);
      if (issue_acc && rd_nz) pending_d[issue_rd] = 1'b1;
      pending_d[0] = 1'b0;
   end

   // Sticky collision flag.
   assign collision_d = collision_q || (wa_eff && wb_eff && (wa_addr == wb_addr));

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
         pending_q   <= '0;
         collision_q <= 1'b0;
      end else begin
         regs_q      <= regs_d;
         pending_q   <= pending_d;
         collision_q <= collision_d;
      end
   end

   assign pending   = pending_q;
   assign collision = collision_q;

endmodule
